// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the memory-port arbiter.
package mem_arbiter_pkg;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a port index or pointer; never below 1 so a single client still has a legal vector.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Masked double-priority encoder: lowest requester at or above ptr, else lowest overall.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 mode,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 valid
);
  logic [NUM_PORTS-1:0] masked, pick_src;
  logic                 found;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      masked[i] = req[i] && (i >= int'(ptr));
    // Fixed mode ignores the pointer and falls straight to the unmasked encoder.
    pick_src = (mode || masked == '0) ? req : masked;
    winner   = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_src[i] && !found) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    valid = |req;
  end
endmodule

// File: rtl/mem_arbiter.sv
// N-client arbiter onto one synchronous memory port; read data is routed back by a one-hot tag pipeline.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ARB_MODE  = ARB_RR,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        wr,
  input  logic [NUM_PORTS-1:0]        wide,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] din,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic                        mem_wide,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  input  logic [DATA_W-1:0]           mem_dout
);
  localparam int PTR_W = port_idx_w(NUM_PORTS);

  logic [PTR_W-1:0]     ptr, win_idx;
  logic [NUM_PORTS-1:0] winner;
  logic                 win_vld;
  logic                 sel_wr, sel_wide;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_din;
  // Stage 0 lines up with the command register; stage MEM_LAT lines up with mem_dout.
  logic [MEM_LAT:0][NUM_PORTS-1:0] rd_tag_pipe;

  rr_picker #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mode   (ARB_MODE == ARB_FIXED),
    .winner (winner),
    .valid  (win_vld)
  );

  always_comb begin
    win_idx  = '0;
    sel_wr   = 1'b0;
    sel_wide = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner[i]) begin
        win_idx  = PTR_W'(i);
        sel_wr   = wr[i];
        sel_wide = wide[i];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_din  = din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant  = nreset ? winner : '0;
  assign rvalid = rd_tag_pipe[MEM_LAT];
  assign rdata  = (|rvalid) ? mem_dout : '0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr         <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wide    <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      rd_tag_pipe <= '0;
    end else begin
      mem_en <= win_vld;
      mem_wr <= win_vld && sel_wr;
      if (win_vld) begin
        mem_wide <= sel_wide;
        mem_addr <= sel_addr;
        mem_din  <= sel_din;
      end
      if (ARB_MODE == ARB_RR && win_vld)
        ptr <= (win_idx == PTR_W'(NUM_PORTS-1)) ? '0 : win_idx + PTR_W'(1);
      rd_tag_pipe[0] <= (win_vld && !sel_wr) ? winner : '0;
      for (int i = 1; i <= MEM_LAT; i++)
        rd_tag_pipe[i] <= rd_tag_pipe[i-1];
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin, fixed-priority and 1-port/2-latency instances with memory models.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
  } exp_t;
  exp_t        q_a[$];
  logic [15:0] q_c[$];

  // Instance A: 3 ports, round-robin, latency 1
  logic [2:0]  req_a, wr_a, wide_a, grant_a, rvalid_a;
  logic [47:0] addr_a, din_a;
  logic [15:0] rdata_a, maddr_a, mdin_a, mdout_a;
  logic        men_a, mwr_a, mwide_a;
  // Instance B: 3 ports, fixed priority
  logic [2:0]  req_b, wr_b, wide_b, grant_b, rvalid_b;
  logic [47:0] addr_b, din_b;
  logic [15:0] rdata_b, maddr_b, mdin_b;
  logic [15:0] mdout_b = 16'h0;
  logic        men_b, mwr_b, mwide_b;
  // Instance C: 1 port, latency 2
  logic        req_c, wr_c, wide_c, grant_c, rvalid_c;
  logic [15:0] addr_c, din_c, rdata_c, maddr_c, mdin_c, mdout_c, rd1_c;
  logic        men_c, mwr_c, mwide_c;

  logic [15:0] mem_a [256];
  logic [15:0] mem_c [256];

  mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(0), .MEM_LAT(1)) u_a (
    .clk(clk), .nreset(nreset), .req(req_a), .wr(wr_a), .wide(wide_a), .addr(addr_a), .din(din_a),
    .grant(grant_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_en(men_a), .mem_wr(mwr_a),
    .mem_wide(mwide_a), .mem_addr(maddr_a), .mem_din(mdin_a), .mem_dout(mdout_a));

  mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(1), .MEM_LAT(1)) u_b (
    .clk(clk), .nreset(nreset), .req(req_b), .wr(wr_b), .wide(wide_b), .addr(addr_b), .din(din_b),
    .grant(grant_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_en(men_b), .mem_wr(mwr_b),
    .mem_wide(mwide_b), .mem_addr(maddr_b), .mem_din(mdin_b), .mem_dout(mdout_b));

  mem_arbiter #(.NUM_PORTS(1), .ARB_MODE(0), .MEM_LAT(2)) u_c (
    .clk(clk), .nreset(nreset), .req(req_c), .wr(wr_c), .wide(wide_c), .addr(addr_c), .din(din_c),
    .grant(grant_c), .rvalid(rvalid_c), .rdata(rdata_c), .mem_en(men_c), .mem_wr(mwr_c),
    .mem_wide(mwide_c), .mem_addr(maddr_c), .mem_din(mdin_c), .mem_dout(mdout_c));

  // Synchronous memory models
  always @(posedge clk) begin
    if (men_a) begin
      if (mwr_a) begin
        if (mwide_a) mem_a[maddr_a[7:0]] <= mdin_a;
        else         mem_a[maddr_a[7:0]][7:0] <= mdin_a[7:0];
      end else mdout_a <= mem_a[maddr_a[7:0]];
    end
    if (men_c && !mwr_c) rd1_c <= mem_c[maddr_c[7:0]];
    mdout_c <= rd1_c;
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rvalid_a !== 3'b000) begin
      chk_cnt++;
      if (q_a.size() == 0) $display("FAIL sb_a_unexpected: rvalid %b rdata %h, none expected", rvalid_a, rdata_a);
      else begin
        exp_t e;
        e = q_a.pop_front();
        if (rvalid_a !== e.id || rdata_a !== e.data)
          $display("FAIL sb_a_data: got rvalid %b rdata %h, want %b %h", rvalid_a, rdata_a, e.id, e.data);
        else pass_cnt++;
      end
    end
    if (rvalid_c !== 1'b0) begin
      chk_cnt++;
      if (q_c.size() == 0) $display("FAIL sb_c_unexpected: rdata %h, none expected", rdata_c);
      else begin
        logic [15:0] d;
        d = q_c.pop_front();
        if (rdata_c !== d) $display("FAIL sb_c_data: got %h want %h", rdata_c, d);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    req_a = 3'b111; req_b = 3'b111; req_c = 1'b1;
    #2;
    chk_cnt++;
    if (grant_a !== 3'b000 || grant_b !== 3'b000 || grant_c !== 1'b0)
      $display("FAIL reset_grant: got %b %b %b want 0", grant_a, grant_b, grant_c);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({men_a, mwr_a, mwide_a, rvalid_a} !== 6'b0 || maddr_a !== 16'h0 || mdin_a !== 16'h0 || rdata_a !== 16'h0)
      $display("FAIL reset_outputs: got en %b wr %b wide %b rv %b addr %h din %h rdata %h want all 0",
               men_a, mwr_a, mwide_a, rvalid_a, maddr_a, mdin_a, rdata_a);
    else pass_cnt++;
    req_a = '0; req_b = '0; req_c = 1'b0;
    reset_dut();
  endtask

  task automatic test_single_read();
    tick();
    req_a = 3'b010; wr_a = 3'b000; wide_a = 3'b111; addr_a[16 +: 16] = 16'h0100;
    @(negedge clk);
    chk_cnt++;
    if (grant_a !== 3'b010) $display("FAIL single_grant: got %b want 010", grant_a);
    else pass_cnt++;
    q_a.push_back('{id: 3'b010, data: 16'hBEEF});
    tick();
    req_a = 3'b000;
    @(negedge clk);
    chk_cnt++;
    if (men_a !== 1'b1 || mwr_a !== 1'b0 || maddr_a !== 16'h0100)
      $display("FAIL single_cmd: got en %b wr %b addr %h want 1 0 0100", men_a, mwr_a, maddr_a);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_a !== 3'b010 || rdata_a !== 16'hBEEF)
      $display("FAIL single_rdata: got %b %h want 010 beef", rvalid_a, rdata_a);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int p = 0; p < 3; p++) addr_a[p*16 +: 16] = 16'h0020 + 16'(p);
    wr_a = 3'b000; wide_a = 3'b111; req_a = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] id;
      if (c > 0) tick();
      id = 3'b001 << (c % 3);
      @(negedge clk);
      chk_cnt++;
      if (grant_a !== id) $display("FAIL rr_grant_%0d: got %b want %b", c, grant_a, id);
      else pass_cnt++;
      q_a.push_back('{id: id, data: mem_a[8'h20 + 8'(c % 3)]});
      if (c > 0) begin
        chk_cnt++;
        if (men_a !== 1'b1) $display("FAIL rr_mem_en_%0d: got %b want 1", c, men_a);
        else pass_cnt++;
      end
    end
    tick();
    req_a = 3'b000;
    @(negedge clk);
    chk_cnt++;
    if (men_a !== 1'b1) $display("FAIL rr_mem_en_last: got %b want 1", men_a);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (q_a.size() != 0) $display("FAIL rr_drain: %0d reads outstanding, want 0", q_a.size());
    else pass_cnt++;
  endtask

  task automatic test_fixed();
    tick();
    req_b = 3'b101; wr_b = 3'b111; wide_b = 3'b000;
    addr_b = {16'h0202, 16'h0101, 16'h0000}; din_b = {16'h22AA, 16'h1155, 16'h00CC};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk_cnt++;
      if (grant_b !== 3'b001) $display("FAIL fixed_grant_%0d: got %b want 001", c, grant_b);
      else pass_cnt++;
    end
    tick();
    req_b = 3'b100;
    @(negedge clk);
    chk_cnt++;
    if (grant_b !== 3'b100) $display("FAIL fixed_port2: got %b want 100", grant_b);
    else pass_cnt++;
    chk_cnt++;
    if (men_b !== 1'b1 || mwr_b !== 1'b1 || mwide_b !== 1'b0 || maddr_b !== 16'h0000 || mdin_b !== 16'h00CC)
      $display("FAIL fixed_cmd: got en %b wr %b wide %b addr %h din %h want 1 1 0 0000 00cc",
               men_b, mwr_b, mwide_b, maddr_b, mdin_b);
    else pass_cnt++;
    tick();
    req_b = 3'b000;
    @(negedge clk);
    chk_cnt++;
    if (maddr_b !== 16'h0202 || mdin_b !== 16'h22AA || rvalid_b !== 3'b000)
      $display("FAIL fixed_port2_cmd: got addr %h din %h rv %b want 0202 22aa 000", maddr_b, mdin_b, rvalid_b);
    else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    tick();
    req_a = 3'b100; wr_a = 3'b100; wide_a = 3'b111;
    addr_a[32 +: 16] = 16'h0040; din_a[32 +: 16] = 16'h1234;
    @(negedge clk);
    chk_cnt++;
    if (grant_a !== 3'b100) $display("FAIL wr_grant: got %b want 100", grant_a);
    else pass_cnt++;
    tick();
    req_a = 3'b001; wr_a = 3'b000; addr_a[0 +: 16] = 16'h0040;
    @(negedge clk);
    chk_cnt++;
    if (grant_a !== 3'b001) $display("FAIL rd_grant: got %b want 001", grant_a);
    else pass_cnt++;
    q_a.push_back('{id: 3'b001, data: 16'h1234});
    chk_cnt++;
    if (mwr_a !== 1'b1 || mwide_a !== 1'b1 || maddr_a !== 16'h0040 || mdin_a !== 16'h1234)
      $display("FAIL wr_cmd: got wr %b wide %b addr %h din %h want 1 1 0040 1234", mwr_a, mwide_a, maddr_a, mdin_a);
    else pass_cnt++;
    tick();
    req_a = 3'b000;
    @(negedge clk);
    chk_cnt++;
    if (men_a !== 1'b1 || mwr_a !== 1'b0 || rvalid_a !== 3'b000)
      $display("FAIL rd_cmd: got en %b wr %b rv %b want 1 0 000", men_a, mwr_a, rvalid_a);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_a !== 3'b001 || rdata_a !== 16'h1234)
      $display("FAIL wr_rd_data: got %b %h want 001 1234", rvalid_a, rdata_a);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_a !== 3'b000) $display("FAIL wr_no_rvalid: got %b want 000", rvalid_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    tick();
    req_a = 3'b010; wr_a = 3'b000; addr_a[16 +: 16] = 16'h0100;
    @(negedge clk);
    chk_cnt++;
    if (grant_a !== 3'b010) $display("FAIL mid_grant: got %b want 010", grant_a);
    else pass_cnt++;
    tick();
    nreset = 1'b0;
    req_a = 3'b000;
    #1;
    chk_cnt++;
    if (grant_a !== 3'b000 || men_a !== 1'b0 || maddr_a !== 16'h0 || rvalid_a !== 3'b000 || rdata_a !== 16'h0)
      $display("FAIL mid_reset_outputs: got grant %b en %b addr %h rv %b rdata %h want all 0",
               grant_a, men_a, maddr_a, rvalid_a, rdata_a);
    else pass_cnt++;
    tick();
    nreset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (rvalid_a !== 3'b000) $display("FAIL mid_dropped_%0d: got rvalid %b want 000", c, rvalid_a);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    tick();
    req_c = 1'b1; wr_c = 1'b0; wide_c = 1'b1; addr_c = 16'h0010;
    @(negedge clk);
    chk_cnt++;
    if (grant_c !== 1'b1) $display("FAIL b2b_grant0: got %b want 1", grant_c);
    else pass_cnt++;
    q_c.push_back(16'hA5A5);
    tick();
    addr_c = 16'h0011;
    @(negedge clk);
    chk_cnt++;
    if (grant_c !== 1'b1 || maddr_c !== 16'h0010) $display("FAIL b2b_grant1: got %b addr %h want 1 0010", grant_c, maddr_c);
    else pass_cnt++;
    q_c.push_back(16'h5A5A);
    tick();
    req_c = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_c !== 1'b0 || maddr_c !== 16'h0011) $display("FAIL b2b_t2: got rv %b addr %h want 0 0011", rvalid_c, maddr_c);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_c !== 1'b1 || rdata_c !== 16'hA5A5) $display("FAIL b2b_t3: got %b %h want 1 a5a5", rvalid_c, rdata_c);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_c !== 1'b1 || rdata_c !== 16'h5A5A) $display("FAIL b2b_t4: got %b %h want 1 5a5a", rvalid_c, rdata_c);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rvalid_c !== 1'b0) $display("FAIL b2b_t5: got %b want 0", rvalid_c);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0;
    req_a = '0; wr_a = '0; wide_a = '0; addr_a = '0; din_a = '0;
    req_b = '0; wr_b = '0; wide_b = '0; addr_b = '0; din_b = '0;
    req_c = '0; wr_c = '0; wide_c = '0; addr_c = '0; din_c = '0;
    mem_a[8'h00] = 16'hBEEF;
    mem_a[8'h20] = 16'h1111; mem_a[8'h21] = 16'h2222; mem_a[8'h22] = 16'h3333;
    mem_c[8'h10] = 16'hA5A5; mem_c[8'h11] = 16'h5A5A;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed();
    test_write_then_read();
    test_reset_mid_read();
    test_back_to_back();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (q_a.size() != 0 || q_c.size() != 0)
      $display("FAIL final_drain: outstanding a=%0d c=%0d want 0", q_a.size(), q_c.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised N-client arbiter that shares one synchronous memory port among several bus masters, such as CPU, video fetch and a future DMA/blitter. It replaces direct one-master-per-port wiring of the memory block, so extra masters can be added without more RAM ports. It accepts one access per cycle, preserves the byte/word ("wide") access mode and routes read data back to the issuing client with a valid pulse.

Parameters:
NUM_PORTS, 3, number of clients (1..8)
ADDR_W, 16, address width
DATA_W, 16, data width (wide access = full width, narrow = low 8 bits)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
MEM_LAT, 1, memory read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
req  in  NUM_PORTS  per-client access request, held until granted
wr  in  NUM_PORTS  per-client write (1) / read (0)
wide  in  NUM_PORTS  per-client word (1) / byte (0) access
addr  in  NUM_PORTS*ADDR_W  packed client addresses, port i at [i*ADDR_W +: ADDR_W]
din  in  NUM_PORTS*DATA_W  packed client write data
grant  out  NUM_PORTS  one-hot pulse: command accepted this cycle
rvalid  out  NUM_PORTS  one-hot pulse: rdata belongs to this client
rdata  out  DATA_W  read data shared by all clients, qualified by rvalid
mem_en  out  1  memory enable
mem_wr  out  1  memory write
mem_wide  out  1  memory word access
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data

Behaviour:
- Reset is asynchronous on nreset low, per the team decision. While reset is asserted: grant=0, rvalid=0, mem_en=0, mem_wr=0, mem_wide=0, mem_addr=0, mem_din=0, rdata=0, round-robin pointer=0, read-tag pipeline cleared.
- Reset released mid-operation: any read in flight is dropped and no rvalid is issued for it.
- Cycle T arbitration (combinational): the winner is chosen among req bits. grant[winner]=1 in cycle T. The client may drop or change req at T+1.
- Cycle T+1: the winner's wr/wide/addr/din are presented on mem_* from registers, with mem_en=1. mem_en=0 when there was no winner.
- Reads: at T+1+MEM_LAT, rvalid[winner]=1 and rdata=mem_dout. Request-to-data latency is 1+MEM_LAT cycles.
- Writes produce no rvalid.
- Throughput: one grant per cycle, with back-to-back grants to different or the same client. A tag shift register of depth MEM_LAT carries the one-hot client ID and the read flag.
- Round-robin (ARB_MODE=0): search starts at pointer p and wraps modulo NUM_PORTS. After a grant to port k, p=(k+1) mod NUM_PORTS; p is unchanged with no grant. Any continuously requesting client is granted within NUM_PORTS cycles.
- Fixed (ARB_MODE=1): the lowest index wins and the pointer is unused. Starvation of higher indices is permitted.
- Width rules: wide and addr are passed through unmodified. Alignment is the memory's responsibility and the arbiter performs no checks.
- NUM_PORTS=1: grant=req, which is a legal degenerate case.
- At most one grant bit and one rvalid bit are high in any cycle. grant and rvalid for different transactions may coincide in the same cycle.

Decomposition:
- Shared package: ARB_RR=0, ARB_FIXED=1 constants, plus a port-index width function clog2(NUM_PORTS).
- One sub-module, rr_picker. Inputs: req vector, pointer, mode. Outputs: one-hot winner and valid. Implementation is a masked double-priority encoder.
- mem_arbiter holds the pointer, the command register and the tag pipeline.

Test Plan:
- Single read: port 1 requests a read of addr 0x0100 at T, memory returns 0xBEEF -> grant[1] at T, mem_en=1/mem_addr=0x0100 at T+1, rvalid[1]=1 with rdata=0xBEEF at T+2 (MEM_LAT=1).
- Round-robin fairness: ports 0, 1 and 2 hold req for 6 cycles from reset -> grant order 0,1,2,0,1,2, with no idle mem_en cycles.
- Fixed mode (ARB_MODE=1): ports 0 and 2 hold req for 4 cycles -> port 0 is granted all 4 cycles and port 2 only after port 0 drops req.
- Write then read: port 2 writes 0x1234 wide to 0x0040, then port 0 reads 0x0040 next cycle -> mem_wr=1 then 0 on consecutive cycles, rvalid[0] with 0x1234, no rvalid[2].
- Reset mid-read: nreset pulled low the cycle after grant -> all outputs are 0 immediately, and no rvalid appears after release.
- MEM_LAT=2, NUM_PORTS=1: back-to-back reads of 0x10 and 0x11 -> rvalid at T+3 and T+4 with the correct data in order.
